// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU front end:
//   - RESET_PC_DEFAULT : default PC loaded on reset
//   - PC_*             : pc_control encodings driven by the decoder
//   - fetch_state_e    : fetch FSM states
//   - branch_offset()  : sign-extended, word-scaled branch displacement
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [2:0] PC_SEQ  = 3'b000;
    localparam logic [2:0] PC_BEQ  = 3'b001;
    localparam logic [2:0] PC_BNE  = 3'b010;
    localparam logic [2:0] PC_JUMP = 3'b011;
    localparam logic [2:0] PC_JR   = 3'b100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        ERROR = 2'd3
    } fetch_state_e;

    // 16-bit immediate -> byte offset (sign-extended, shifted left by 2).
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// ---------------------------------------------------------------------------
// next_pc_calc
// Purely combinational next-PC selection.
// Ports:
//   pc         [31:0] in  : current PC
//   instr      [31:0] in  : instruction being retired (imm16 / target26)
//   pc_control [2:0]  in  : next-PC select (see cpu_pkg PC_*)
//   alu_zero          in  : ALU zero flag for BEQ/BNE
//   jr_target  [31:0] in  : register value for JR/JALR
//   next_pc    [31:0] out : selected next PC (unaligned values passed through)
// ---------------------------------------------------------------------------
module next_pc_calc
    import cpu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic [2:0]  pc_control,
    input  logic        alu_zero,
    input  logic [31:0] jr_target,
    output logic [31:0] next_pc
);

    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] jump_target;

    // Opcode/register fields are not involved in target arithmetic.
    logic        unused_instr_hi;
    assign unused_instr_hi = ^instr[31:26];

    // All arithmetic wraps modulo 2^32 by construction of the 32-bit sums.
    assign pc_plus4      = pc + 32'd4;
    assign branch_target = pc_plus4 + branch_offset(instr[15:0]);
    assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        case (pc_control)
            PC_SEQ:  next_pc = pc_plus4;
            PC_BEQ:  next_pc = alu_zero ? branch_target : pc_plus4;
            PC_BNE:  next_pc = alu_zero ? pc_plus4 : branch_target;
            PC_JUMP: next_pc = jump_target;
            PC_JR:   next_pc = jr_target;
            default: next_pc = pc_plus4;  // reserved encodings fall through
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage: requests one instruction at a time from
// instruction memory, holds it for the decoder until it retires, then
// advances the PC using next_pc_calc.
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN
//   defined   : a retire to a misaligned target keeps pc, raises the sticky
//               align_err and parks the FSM in ERROR until reset.
//   undefined : next_pc[1:0] forced to 0, align_err tied low.
//
// Ports:
//   clk, rst_n                : clock (rising edge), async active-low reset
//   pc_control[2:0], alu_zero,
//   jr_target[31:0]           : next-PC controls, sampled on retire only
//   stall                     : holds the current instruction in HOLD
//   imem_req, imem_addr[31:0] : memory request (addr == pc while requesting)
//   imem_ack, imem_rdata      : memory response, only honoured in FETCH
//   instr[31:0], instr_valid  : registered instruction to the decoder
//   pc[31:0], pc_plus4[31:0]  : current PC and link value
//   align_err                 : sticky misaligned-target flag
// ---------------------------------------------------------------------------
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  pc_control,
    input  logic        alu_zero,
    input  logic [31:0] jr_target,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        align_err
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  instr_q;
    logic         instr_valid_q;
    logic         imem_req_q;
    logic [31:0]  next_pc_raw;
    logic [31:0]  pc_d;

    next_pc_calc u_next_pc_calc (
        .pc         (pc_q),
        .instr      (instr_q),
        .pc_control (pc_control),
        .alu_zero   (alu_zero),
        .jr_target  (jr_target),
        .next_pc    (next_pc_raw)
    );

`ifdef FETCH_ALIGN_CHECK_EN
    logic align_err_q;
    logic misaligned;

    assign pc_d       = next_pc_raw;
    assign misaligned = |next_pc_raw[1:0];
    assign align_err  = align_err_q;
`else
    // Low bits are discarded, so every retire target is word aligned.
    logic unused_low_bits;
    assign unused_low_bits = ^next_pc_raw[1:0];
    assign pc_d            = {next_pc_raw[31:2], 2'b00};
    assign align_err       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            align_err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    state_q    <= FETCH;
                    imem_req_q <= 1'b1;
                end
                FETCH: begin
                    // Wait indefinitely; the request stays up until acked.
                    if (imem_ack) begin
                        instr_q       <= imem_rdata;
                        instr_valid_q <= 1'b1;
                        imem_req_q    <= 1'b0;
                        state_q       <= HOLD;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        instr_valid_q <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
                        if (misaligned) begin
                            align_err_q <= 1'b1;
                            imem_req_q  <= 1'b0;
                            state_q     <= ERROR;
                        end else begin
                            pc_q       <= pc_d;
                            imem_req_q <= 1'b1;
                            state_q    <= FETCH;
                        end
`else
                        pc_q       <= pc_d;
                        imem_req_q <= 1'b1;
                        state_q    <= FETCH;
`endif
                    end
                end
                ERROR: begin
                    // Terminal until reset.
                    imem_req_q    <= 1'b0;
                    instr_valid_q <= 1'b0;
                end
                default: begin
                    state_q    <= IDLE;
                    imem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit: directed vector table, hand-written
// multi-cycle sequences and a randomized loop against a reference model.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  pc_control;
    logic        alu_zero;
    logic [31:0] jr_target;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        align_err;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_pc;
    logic        in_error = 1'b0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_control  (pc_control),
        .alu_zero    (alu_zero),
        .jr_target   (jr_target),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .align_err   (align_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference: next PC from the instruction-set rules, in plain arithmetic.
    function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] ins,
                                             input logic [2:0] ctl, input logic z,
                                             input logic [31:0] jr);
        logic [31:0] seq;
        int          off;
        logic [31:0] tgt;
        seq = cur + 32'd4;
        off = int'($signed(ins[15:0])) * 4;
        case (ctl)
            3'd1:    tgt = z  ? seq + 32'(off) : seq;
            3'd2:    tgt = !z ? seq + 32'(off) : seq;
            3'd3:    tgt = (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 32'd4);
            3'd4:    tgt = jr;
            default: tgt = seq;
        endcase
        return tgt;
    endfunction

    // One full instruction: FETCH (with ack delay), HOLD (with stalls), retire.
    // Entered and left at a negedge with the DUT in FETCH.
    task automatic run_instr(input logic [31:0] rdata, input logic [2:0] ctl,
                             input logic z, input logic [31:0] jr,
                             input int ack_delay, input int stall_cycles);
        int n;
        logic [31:0] exp;
        n = 0;
        while (!imem_req && n < 10) begin
            tick();
            n++;
        end
        chk("req_wait", {31'b0, imem_req}, 32'd1);
        if (!imem_req) return;
        chk("fetch_addr", imem_addr, m_pc);
        chk("fetch_plus4", pc_plus4, m_pc + 32'd4);
        for (int i = 0; i < ack_delay; i++) begin
            imem_ack   = 1'b0;
            pc_control = 3'($urandom_range(7));
            jr_target  = $urandom;
            tick();
            chk("req_held", {31'b0, imem_req}, 32'd1);
            chk("pc_in_fetch", pc, m_pc);
        end
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        stall      = 1'b0;
        tick();
        chk("instr_cap", instr, rdata);
        chk("valid_hold", {31'b0, instr_valid}, 32'd1);
        chk("req_drop", {31'b0, imem_req}, 32'd0);
        // Stray acks with junk data while holding must be ignored.
        imem_ack   = 1'($urandom_range(1));
        imem_rdata = $urandom;
        for (int i = 0; i < stall_cycles; i++) begin
            stall      = 1'b1;
            pc_control = 3'($urandom_range(7));
            jr_target  = $urandom;
            tick();
            chk("stall_pc", pc, m_pc);
            chk("stall_instr", instr, rdata);
            chk("stall_valid", {31'b0, instr_valid}, 32'd1);
            chk("stall_req", {31'b0, imem_req}, 32'd0);
        end
        stall      = 1'b0;
        pc_control = ctl;
        alu_zero   = z;
        jr_target  = jr;
        exp        = ref_next(m_pc, rdata, ctl, z, jr);
        tick();
        imem_ack   = 1'b0;
        pc_control = 3'($urandom_range(7));
        stall      = 1'($urandom_range(1));
        chk("retire_valid", {31'b0, instr_valid}, 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
        if (exp[1:0] != 2'b00) begin
            chk("err_pc", pc, m_pc);
            chk("err_flag", {31'b0, align_err}, 32'd1);
            chk("err_req", {31'b0, imem_req}, 32'd0);
            in_error = 1'b1;
            return;
        end
`else
        exp = exp & 32'hFFFF_FFFC;
`endif
        chk("retire_pc", pc, exp);
        chk("retire_req", {31'b0, imem_req}, 32'd1);
        chk("align_err_low", {31'b0, align_err}, 32'd0);
        m_pc = exp;
    endtask

    typedef struct {
        string       name;
        logic [31:0] set_pc;
        logic [31:0] ins;
        logic [2:0]  ctl;
        logic        z;
        logic [31:0] jr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{"beq_taken",  32'h0000_0100, 32'h1000_FFFE, 3'd1, 1'b1, 32'h0, 32'h0000_00FC};
        vecs[1]  = '{"beq_not",    32'h0000_0100, 32'h1000_FFFE, 3'd1, 1'b0, 32'h0, 32'h0000_0104};
        vecs[2]  = '{"bne_taken",  32'h0000_0100, 32'h1400_0004, 3'd2, 1'b0, 32'h0, 32'h0000_0114};
        vecs[3]  = '{"bne_not",    32'h0000_0100, 32'h1400_0004, 3'd2, 1'b1, 32'h0, 32'h0000_0104};
        vecs[4]  = '{"jump",       32'h1000_0000, 32'h0800_0010, 3'd3, 1'b0, 32'h0, 32'h1000_0040};
        vecs[5]  = '{"jr",         32'h0000_0200, 32'h0000_0008, 3'd4, 1'b0, 32'h0000_4000, 32'h0000_4000};
        vecs[6]  = '{"rsvd_101",   32'h0000_0300, 32'h1000_0010, 3'd5, 1'b1, 32'h0000_8000, 32'h0000_0304};
        vecs[7]  = '{"rsvd_111",   32'h0000_0300, 32'h1000_0010, 3'd7, 1'b1, 32'h0000_8000, 32'h0000_0304};
        vecs[8]  = '{"seq_wrap",   32'hFFFF_FFFC, 32'h0000_0000, 3'd0, 1'b0, 32'h0, 32'h0000_0000};
        vecs[9]  = '{"br_wrap",    32'hFFFF_FFF8, 32'h1000_0001, 3'd1, 1'b1, 32'h0, 32'h0000_0000};
        vecs[10] = '{"jump_wrap",  32'hFFFF_FFFC, 32'h0BFF_FFFF, 3'd3, 1'b0, 32'h0, 32'h0FFF_FFFC};
        vecs[11] = '{"br_min_imm", 32'h0002_0000, 32'h1000_8000, 3'd1, 1'b1, 32'h0, 32'h0000_0004};

        rst_n      = 1'b0;
        pc_control = 3'd0;
        alu_zero   = 1'b0;
        jr_target  = 32'h0;
        stall      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        m_pc       = RST_PC;
        tick();
        tick();

        // Reset state
        chk("rst_pc", pc, RST_PC);
        chk("rst_instr", instr, 32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_align", {31'b0, align_err}, 32'd0);

        // Release: IDLE, then FETCH with ack on its first cycle
        rst_n = 1'b1;
        chk("idle_req", {31'b0, imem_req}, 32'd0);
        tick();
        chk("first_req", {31'b0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h2108_0001;
        tick();
        imem_ack = 1'b0;
        chk("first_valid", {31'b0, instr_valid}, 32'd1);
        chk("first_instr", instr, 32'h2108_0001);
        chk("first_plus4", pc_plus4, 32'd4);
        pc_control = 3'd0;
        tick();
        chk("first_retire", pc, 32'd4);
        m_pc = 32'd4;

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            run_instr($urandom, PC_JR_TB(), 1'b0, vecs[i].set_pc, 0, 0);
            run_instr(vecs[i].ins, vecs[i].ctl, vecs[i].z, vecs[i].jr, i % 3, i % 2);
            chk(vecs[i].name, pc, vecs[i].exp);
        end

        // Long stall: retire on the first stall=0 cycle
        run_instr(32'h1234_5678, 3'd0, 1'b0, 32'h0, 2, 5);

        // Randomized instructions against the model
        for (int i = 0; i < 40; i++) begin
            run_instr($urandom, 3'($urandom_range(7)), 1'($urandom_range(1)),
                      $urandom & 32'hFFFF_FFFC, $urandom_range(3), $urandom_range(3));
        end

        // Reset mid-FETCH with a late ack
        imem_ack = 1'b0;
        tick();
        tick();
        tick();
        chk("pre_rst_req", {31'b0, imem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_pc", pc, RST_PC);
        chk("async_valid", {31'b0, instr_valid}, 32'd0);
        chk("async_req", {31'b0, imem_req}, 32'd0);
        @(negedge clk);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        rst_n = 1'b1;
        tick();
        imem_ack = 1'b0;
        chk("stray_valid", {31'b0, instr_valid}, 32'd0);
        chk("stray_instr", instr, 32'h0);
        chk("post_rst_pc", pc, RST_PC);
        chk("post_rst_req", {31'b0, imem_req}, 32'd1);
        m_pc = RST_PC;

        // Misaligned JR target
        run_instr(32'h0000_0008, 3'd4, 1'b0, 32'h0000_0202, 1, 0);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("jr_misalign_err", {31'b0, in_error}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            imem_ack = 1'b1;
            tick();
            chk("err_stuck_req", {31'b0, imem_req}, 32'd0);
            chk("err_stuck_valid", {31'b0, instr_valid}, 32'd0);
            chk("err_stuck_flag", {31'b0, align_err}, 32'd1);
        end
`else
        chk("jr_misalign_pc", pc, 32'h0000_0200);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    function automatic logic [2:0] PC_JR_TB();
        return 3'b100;
    endfunction

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
- REQ-001 The block SHALL have a parameter RESET_PC, default 32'h0000_0000: the PC value loaded on reset.
- REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
- REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
- REQ-004 The block SHALL have port pc_control, input, 3 bits: next-PC select from the decoder.
- REQ-005 The block SHALL have port alu_zero, input, 1 bit: ALU zero flag, used for branch resolution.
- REQ-006 The block SHALL have port jr_target, input, 32 bits: register-file rs value, used for JR/JALR.
- REQ-007 The block SHALL have port stall, input, 1 bit: holds the current instruction when high.
- REQ-008 The block SHALL have ports imem_req (output, 1 bit) and imem_addr (output, 32 bits): the instruction memory request.
- REQ-009 The block SHALL have ports imem_ack (input, 1 bit) and imem_rdata (input, 32 bits): the memory response, valid while imem_ack is high.
- REQ-010 The block SHALL have ports instr (output, 32 bits) and instr_valid (output, 1 bit): the registered instruction sent to the decoder.
- REQ-011 The block SHALL have ports pc (output, 32 bits) and pc_plus4 (output, 32 bits): the current PC and the link value.
- REQ-012 The block SHALL have port align_err, output, 1 bit: sticky misaligned-target flag.

Function
- REQ-013 The block SHALL implement a four-state FSM with states IDLE, FETCH, HOLD and ERROR.
- REQ-014 The FSM SHALL always move from IDLE to FETCH one cycle after reset release.
- REQ-015 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc; the block SHALL wait any number of cycles for imem_ack.
- REQ-016 In FETCH, on imem_ack=1 the block SHALL capture imem_rdata into instr, set instr_valid=1 and move to HOLD.
- REQ-017 In HOLD with stall=1, the block SHALL keep pc, instr and instr_valid unchanged and keep imem_req at 0.
- REQ-018 In HOLD with stall=0, the instruction SHALL retire: pc loads next_pc, instr_valid goes to 0, and the FSM moves to FETCH; best-case throughput is one instruction per 2 cycles.
- REQ-019 next_pc SHALL be decoded from pc_control as follows:
  - 000: pc+4.
  - 001 (BEQ): branch target if alu_zero=1, else pc+4.
  - 010 (BNE): branch target if alu_zero=0, else pc+4.
  - 011 (J/JAL): {pc_plus4[31:28], instr[25:0], 2'b00}.
  - 100 (JR/JALR): jr_target.
  - 101-111 (reserved): pc+4.
- REQ-020 The branch target SHALL equal pc_plus4 + (sign-extended instr[15:0] << 2), computed modulo 2^32.
- REQ-021 pc_plus4 SHALL equal pc+4 modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- REQ-022 pc_control, alu_zero and jr_target SHALL be sampled only in the HOLD-retire cycle and ignored in all other states.
- REQ-023 An imem_ack received outside FETCH SHALL be ignored.

Reset
- REQ-024 Assertion of rst_n=0 SHALL asynchronously force: pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, align_err=0, state IDLE.
- REQ-025 Reset asserted during FETCH SHALL abort the outstanding request, and a late imem_ack SHALL be discarded.

Configuration
- REQ-026 With macro FETCH_ALIGN_CHECK_EN defined, a retire whose next_pc[1:0]!=0 SHALL leave pc unchanged, set align_err=1 and enter ERROR.
- REQ-027 The ERROR state SHALL hold imem_req=0 and instr_valid=0 until reset.
- REQ-028 Without FETCH_ALIGN_CHECK_EN, next_pc[1:0] SHALL be forced to 2'b00, align_err SHALL be tied 0, and ERROR SHALL be unreachable.

Structure
- REQ-029 The shared package cpu_pkg SHALL hold: the pc_control encodings (PC_SEQ, PC_BEQ, PC_BNE, PC_JUMP, PC_JR), the fetch state enum, and the RESET_PC default.
- REQ-030 Next-PC arithmetic SHALL live in one combinational sub-module, next_pc_calc, with inputs pc, instr, pc_control, alu_zero and jr_target, and output next_pc.

Verification
- REQ-031 Reset release, imem_ack returned on the first FETCH cycle -> imem_addr=0; instr_valid=1 two cycles after IDLE; pc_plus4=4.
- REQ-032 pc=0x100, instr imm=0xFFFE, pc_control=001, alu_zero=1 -> next pc=0x0FC. Same case with alu_zero=0 -> next pc=0x104.
- REQ-033 pc=0x1000_0000, pc_control=011, instr[25:0]=0x0000010 -> next pc=0x1000_0040.
- REQ-034 stall=1 for 5 cycles in HOLD -> pc, instr and instr_valid constant and imem_req=0 throughout; retire occurs on the first cycle with stall=0.
- REQ-035 imem_ack delayed 3 cycles, then rst_n pulsed low mid-FETCH -> pc=RESET_PC, instr_valid=0, and a following stray ack is ignored.
- REQ-036 pc_control=100, jr_target=0x202 -> with FETCH_ALIGN_CHECK_EN: align_err=1, FSM in ERROR, imem_req=0; without it: next pc=0x200.
